// File: rtl/reset_request_arbiter.sv
// reset_request_arbiter: round-robin arbiter that serialises core reset requests through one reset
// generator (start pulse, wait for core reset assert/release, acknowledge, cooldown).
// Optional completed-sequence counter enabled by defining RESET_ARB_COUNTER_EN.
module reset_request_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ASSERT_TIMEOUT = 8,
   parameter int COOLDOWN       = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] ack_o,
   output logic               start_o,
   input  logic               core_rst_i,
   output logic               busy_o,
   output logic [2:0]         grant_id_o,
   output logic               timeout_o,
   output logic [7:0]         reset_count_o
);
   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_ISSUE        = 3'd1;
   localparam logic [2:0] S_WAIT_ASSERT  = 3'd2;
   localparam logic [2:0] S_WAIT_RELEASE = 3'd3;
   localparam logic [2:0] S_ACK          = 3'd4;
   localparam logic [2:0] S_COOLDOWN     = 3'd5;
   logic [2:0] r_state;
   logic [2:0] w_next;
   logic [2:0] r_grant;
   logic [2:0] w_rr_id;
   logic       w_rr_hit;
   logic [7:0] r_cnt;
   logic       r_timeout;
   logic       w_timeout_hit;
   // r_cnt counts WAIT_ASSERT cycles; +2 turns it into edges elapsed since start_o rose
   assign w_timeout_hit = (r_cnt + 8'd2) >= 8'(ASSERT_TIMEOUT);
   // Round-robin pick: scan downwards so the requester right after the last grant wins
   always_comb begin
      w_rr_hit = 1'b0;
      w_rr_id  = r_grant;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (|(req_i & (NUM_REQ'(1) << ((int'(r_grant) + k) % NUM_REQ)))) begin
            w_rr_hit = 1'b1;
            w_rr_id  = 3'((int'(r_grant) + k) % NUM_REQ);
         end
      end
   end
   // State register
   always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
   // Next-state logic; illegal encodings fall back to IDLE
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:         w_next = w_rr_hit ? S_ISSUE : S_IDLE;
         S_ISSUE:        w_next = S_WAIT_ASSERT;
         S_WAIT_ASSERT:  w_next = core_rst_i ? S_WAIT_RELEASE : (w_timeout_hit ? S_ACK : S_WAIT_ASSERT);
         S_WAIT_RELEASE: w_next = core_rst_i ? S_WAIT_RELEASE : S_ACK;
         S_ACK:          w_next = (COOLDOWN == 0) ? S_IDLE : S_COOLDOWN;
         S_COOLDOWN:     w_next = (r_cnt <= 8'd1) ? S_IDLE : S_COOLDOWN;
         default:        w_next = S_IDLE;
      endcase
   end
   // Moore outputs decoded from the state, so a reset can never leave a stray pulse behind
   always_comb begin
      start_o    = r_state == S_ISSUE;
      busy_o     = r_state != S_IDLE;
      ack_o      = (r_state == S_ACK) ? (NUM_REQ'(1) << r_grant) : '0;
      grant_id_o = r_grant;
      timeout_o  = r_timeout;
   end
   // Grant latch, shared timeout/cooldown counter and sticky timeout flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant   <= 3'(NUM_REQ - 1);
         r_cnt     <= 8'd0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_rr_hit) r_grant <= w_rr_id;
         r_cnt <= (r_state == S_ISSUE)       ? 8'd0 :
                  (r_state == S_WAIT_ASSERT) ? r_cnt + 8'd1 :
                  (r_state == S_ACK)         ? 8'(COOLDOWN) :
                  (r_state == S_COOLDOWN)    ? r_cnt - 8'd1 : r_cnt;
         if (r_state == S_WAIT_ASSERT && !core_rst_i && w_timeout_hit) r_timeout <= 1'b1;
      end
   end
`ifdef RESET_ARB_COUNTER_EN
   logic [7:0] r_count;
   logic       w_seq_done;
   assign w_seq_done = (r_state == S_WAIT_RELEASE) && !core_rst_i;
   // Completed core reset sequences, saturating at 255
   always_ff @(posedge clk) r_count <= rst ? 8'd0 : (w_seq_done && r_count != 8'hFF) ? r_count + 8'd1 : r_count;
   assign reset_count_o = r_count;
`else
   assign reset_count_o = 8'd0;
`endif
endmodule

// File: tb/tb_reset_request_arbiter.sv
// tb_reset_request_arbiter: vector table plus hand sequences; expected acks are queued on stimulus
// and popped as the arbiter acknowledges, with a small reset-generator model driving core_rst_i.
module tb_reset_request_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ASSERT_TIMEOUT = 8;
   localparam int COOLDOWN = 4;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req_i = 4'd0;
   logic [3:0] ack_o;
   logic       start_o;
   logic       core_rst_i = 1'b0;
   logic       busy_o;
   logic [2:0] grant_id_o;
   logic       timeout_o;
   logic [7:0] reset_count_o;

   reset_request_arbiter #(.NUM_REQ(NUM_REQ), .ASSERT_TIMEOUT(ASSERT_TIMEOUT), .COOLDOWN(COOLDOWN)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .ack_o(ack_o), .start_o(start_o), .core_rst_i(core_rst_i),
      .busy_o(busy_o), .grant_id_o(grant_id_o), .timeout_o(timeout_o), .reset_count_o(reset_count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      int          dly;
      int          hold;
      int          n;
      logic [15:0] order;
      logic        to;
      int          cnt;
   } vec_t;

   vec_t vecs[7];
   int q[$];
   int n_chk = 0, n_fail = 0;
   int cyc = 0, n_start = 0, last_ack = 0, start_cyc = 0, to_cyc = 0;
   int gen_cnt = 0, g_dly = 2, g_hold = 1;
   bit have_ack = 0, prev_start = 0, prev_busy = 0, prev_to = 0, gen_active = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_cnt(input int n);
`ifdef RESET_ARB_COUNTER_EN
      return (n > 255) ? 255 : n;
`else
      return 0;
`endif
   endfunction

   task automatic step();
      int e;
      @(posedge clk);
      #1;
      cyc++;
      chk("ack_onehot", int'((ack_o & (ack_o - 4'd1)) != 4'd0), 0);
      if (start_o) begin
         chk("start_back_to_back", int'(prev_start), 0);
         chk("grant_to_start_latency", int'(prev_busy), 0);
         if (q.size() > 0) chk("grant_id", int'(grant_id_o), q[0]);
         if (have_ack) chk("cooldown_spacing", int'(cyc - last_ack >= COOLDOWN + 1), 1);
         n_start++;
         start_cyc  = cyc;
         gen_active = 1;
         gen_cnt    = 0;
      end else if (gen_active) begin
         gen_cnt++;
      end
      core_rst_i = gen_active && g_dly >= 0 && gen_cnt + 1 >= g_dly && gen_cnt + 1 < g_dly + g_hold;
      if (timeout_o && !prev_to) to_cyc = cyc;
      if (ack_o != 4'd0) begin
         if (q.size() == 0) chk("ack_unexpected", int'(ack_o), 0);
         else begin
            e = q.pop_front();
            chk("ack_order", int'(ack_o), 1 << e);
         end
         req_i    = req_i & ~ack_o;
         last_ack = cyc;
         have_ack = 1;
      end
      prev_start = start_o;
      prev_busy  = busy_o;
      prev_to    = timeout_o;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      gen_active = 0;
      core_rst_i = 1'b0;
      step();
      step();
      rst      = 1'b0;
      have_ack = 0;
   endtask

   task automatic drain(input int budget, input bit settle);
      int n = 0;
      while (q.size() > 0 && n < budget) begin
         step();
         n++;
      end
      chk("drain_budget", q.size(), 0);
      if (settle) begin
         n = 0;
         while (busy_o && n < 60) begin
            step();
            n++;
         end
         chk("settle_idle", int'(busy_o), 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      vecs[0] = '{4'b0001,  2, 21, 1, 16'h0000, 1'b0, 1};
      vecs[1] = '{4'b1111,  2,  3, 4, 16'h3210, 1'b0, 4};
      vecs[2] = '{4'b0010, -1,  0, 1, 16'h0001, 1'b1, 0};
      vecs[3] = '{4'b1010,  2,  1, 2, 16'h0031, 1'b0, 2};
      vecs[4] = '{4'b0110,  3,  5, 2, 16'h0021, 1'b0, 2};
      vecs[5] = '{4'b1000,  8,  2, 1, 16'h0003, 1'b0, 1};
      vecs[6] = '{4'b0100,  9,  2, 1, 16'h0002, 1'b1, 0};

      do_reset();
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_start", int'(start_o), 0);
      chk("rst_ack", int'(ack_o), 0);
      chk("rst_grant", int'(grant_id_o), NUM_REQ - 1);
      chk("rst_timeout", int'(timeout_o), 0);
      chk("rst_count", int'(reset_count_o), 0);

      for (int i = 0; i < 7; i++) begin
         req_i = 4'd0;
         do_reset();
         n_start = 0;
         g_dly   = vecs[i].dly;
         g_hold  = vecs[i].hold;
         for (int k = 0; k < vecs[i].n; k++) q.push_back(int'(vecs[i].order[4*k +: 4]));
         req_i = vecs[i].req;
         drain(600, 1);
         chk($sformatf("v%0d_starts", i), n_start, vecs[i].n);
         chk($sformatf("v%0d_timeout", i), int'(timeout_o), int'(vecs[i].to));
         chk($sformatf("v%0d_count", i), int'(reset_count_o), exp_cnt(vecs[i].cnt));
         chk($sformatf("v%0d_last_grant", i), int'(grant_id_o), int'(vecs[i].order[4*(vecs[i].n-1) +: 4]));
         if (vecs[i].to) chk($sformatf("v%0d_timeout_latency", i), to_cyc - start_cyc, ASSERT_TIMEOUT);
      end

      // reset pulsed while the generator holds core reset
      req_i = 4'd0;
      do_reset();
      n_start = 0;
      g_dly   = 2;
      g_hold  = 20;
      q.push_back(2);
      req_i = 4'b0100;
      n = 0;
      while (n_start == 0 && n < 20) begin
         step();
         n++;
      end
      repeat (6) step();
      chk("abort_pre_busy", int'(busy_o && core_rst_i), 1);
      rst        = 1'b1;
      gen_active = 0;
      core_rst_i = 1'b0;
      step();
      rst = 1'b0;
      chk("abort_idle", int'(busy_o), 0);
      chk("abort_no_ack", q.size(), 1);
      drain(200, 1);
      chk("abort_starts", n_start, 2);
      chk("abort_count", int'(reset_count_o), exp_cnt(1));
      chk("abort_grant", int'(grant_id_o), 2);

      // requester withdraws while the arbiter waits for core reset to assert
      req_i = 4'd0;
      do_reset();
      n_start = 0;
      g_dly   = 5;
      g_hold  = 2;
      q.push_back(0);
      req_i = 4'b0001;
      n = 0;
      while (n_start == 0 && n < 20) begin
         step();
         n++;
      end
      step();
      step();
      req_i[0] = 1'b0;
      chk("drop_still_busy", int'(busy_o), 1);
      drain(100, 1);
      repeat (10) step();
      chk("drop_starts", n_start, 1);
      chk("drop_grant", int'(grant_id_o), 0);

      // 300 back-to-back sequences exercise counter saturation
      req_i = 4'd0;
      do_reset();
      g_dly  = 2;
      g_hold = 1;
      for (int i = 1; i <= 300; i++) begin
         q.push_back(0);
         req_i[0] = 1'b1;
         drain(60, 0);
         if (i == 255) chk("sat_count_255", int'(reset_count_o), exp_cnt(255));
      end
      chk("sat_count_300", int'(reset_count_o), exp_cnt(300));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
